// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform sequencer: FSM states, one-hot wave codes, buffer depth.
package waveform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_PLAY
    } state_t;

    localparam logic [3:0] WAVE_SINE = 4'b0001;
    localparam logic [3:0] WAVE_TRI  = 4'b0010;
    localparam logic [3:0] WAVE_SQR  = 4'b0100;
    localparam logic [3:0] WAVE_FM   = 4'b1000;

    localparam int N_SAMPLES = 256;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: tick pulses on the last of every CLK_DIV enabled cycles, first tick CLK_DIV-1 cycles after en rises.
// No backpressure; dropping en clears the count so the next period starts from zero.
module sample_tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/waveform_sequencer.sv
// Sequences the waveform converter and loops its buffer to the DAC; conv_start one cycle after run+pending request,
// first dac_valid CLK_DIV cycles into PLAY. No backpressure: the DAC must accept one sample per CLK_DIV cycles.
module waveform_sequencer #(
    parameter int CLK_DIV   = 1000,
    parameter int TIMEOUT   = 16,
    parameter int N_SAMPLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] sw,
    output logic       conv_start,
    output logic [3:0] conv_sel,
    input  logic       conv_rdy,
    output logic [7:0] rd_idx,
    input  logic [7:0] rd_data,
    output logic [7:0] dac_data,
    output logic       dac_valid,
    output logic [3:0] cur_wave,
    output logic       busy,
    output logic       err
);
    import waveform_pkg::*;

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [7:0]    IDX_LAST  = 8'(N_SAMPLES - 1);

    state_t        state;
    logic          pend;
    logic [3:0]    pend_sel;
    logic          buf_valid;
    logic [WW-1:0] wait_cnt;

    logic       req;
    logic       pend_any;
    logic [3:0] next_sel;
    logic       play_en;
    logic       tick;
    logic       last_sample;
    logic       go_start;

    // A request seen this cycle counts as pending, so a change landing on sample 255 is not lost.
    assign req         = is_onehot4(sw) && (sw != cur_wave);
    assign pend_any    = pend || req;
    assign next_sel    = req ? sw : pend_sel;
    assign play_en     = (state == ST_PLAY) && run;
    assign last_sample = tick && (rd_idx == IDX_LAST);
    assign go_start    = run && pend_any &&
                         ((state == ST_IDLE) || ((state == ST_PLAY) && last_sample));

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (play_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend       <= 1'b1;
            pend_sel   <= WAVE_SINE;
            cur_wave   <= WAVE_SINE;
            conv_sel   <= WAVE_SINE;
            conv_start <= 1'b0;
            rd_idx     <= '0;
            dac_data   <= '0;
            dac_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            buf_valid  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            conv_start <= 1'b0;
            dac_valid  <= 1'b0;
            if (req) begin
                pend     <= 1'b1;
                pend_sel <= sw;
            end

            unique case (state)
                ST_IDLE: begin
                    if (run && !pend_any && buf_valid) begin
                        state <= ST_PLAY;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!run) begin
                        // Conversion was abandoned: force a fresh one on the next run.
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        pend      <= 1'b1;
                        buf_valid <= 1'b0;
                    end else if (conv_rdy) begin
                        state     <= ST_PLAY;
                        buf_valid <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        buf_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ST_PLAY: begin
                    if (!run) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        rd_idx <= '0;
                    end else if (tick) begin
                        dac_data  <= rd_data;
                        dac_valid <= 1'b1;
                        rd_idx    <= rd_idx + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (go_start) begin
                state      <= ST_START;
                busy       <= 1'b1;
                conv_start <= 1'b1;
                conv_sel   <= next_sel;
                cur_wave   <= next_sel;
                pend_sel   <= next_sel;
                pend       <= 1'b0;
                err        <= 1'b0;
            end
        end
    end

endmodule
